// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the multiply sequencer state encoding,
// used by the ALU, the EX operand mux and alu_mult_sequencer.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle unsigned multiply (MULTU) by shift-add through the shared EX ALU.
// Owns the ALU and stalls the pipeline while running; delivers HI/LO product.
module alu_mult_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             carry;

  // ALU drive depends on registered state only, so the external
  // alu_a -> alu_result path never loops back through this process.
  always_comb begin
    alu_sel = 1'b0;
    busy    = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = ALU_AND;
    unique case (state_q)
      IDLE: stall = start;
      RUN: begin
        alu_sel = 1'b1;
        busy    = 1'b1;
        stall   = 1'b1;
        alu_a   = acc_q;
        alu_b   = mq_q[0] ? mcand_q : '0;
        alu_op  = ALU_ADD;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    carry   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = op_a;
          mq_d    = op_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Carry out of the WIDTH-bit add recovered by unsigned wrap compare
        carry = (alu_result < acc_q);
        acc_d = {carry, alu_result[WIDTH-1:1]};
        mq_d  = {alu_result[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          hi_d    = acc_d;
          lo_d    = mq_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign product_hi = hi_q;
  assign product_lo = lo_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a behavioural copy of the shared ALU
// on alu_a/alu_b/alu_op; table of products plus abort/ignore/back-to-back sequences.
module tb_alu_mult_sequencer;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_sel;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_op;
  logic             busy, stall, done;
  logic [WIDTH-1:0] product_hi, product_lo;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] last_hi, last_lo;

  always #5 clk = ~clk;

  alu_mult_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_result (alu_result),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLT: alu_result = WIDTH'($signed(alu_a) < $signed(alu_b));
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply from IDLE; pulse_at>0 re-pulses start (7*7) in that RUN cycle.
  task automatic do_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo,
                         input int pulse_at);
    int n;
    bit run_bad, hold_bad;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    #1;
    chk("stall_on_request", {63'd0, stall}, 64'd1);
    tick();
    start    = 1'b0;
    n        = 0;
    run_bad  = 1'b0;
    hold_bad = 1'b0;
    while (!done && n < 100) begin
      if (pulse_at > 0 && n == pulse_at - 1) begin
        start = 1'b1;
        op_a  = 7;
        op_b  = 7;
      end else begin
        start = 1'b0;
      end
      #1;
      if (!stall || !busy || !alu_sel || alu_op !== ALU_ADD) run_bad = 1'b1;
      if (product_hi !== last_hi || product_lo !== last_lo) hold_bad = 1'b1;
      tick();
      n++;
    end
    start = 1'b0;
    chk("done_latency", 64'(n), 64'(WIDTH));
    chk("run_flags", {63'd0, run_bad}, 64'd0);
    chk("product_hold", {63'd0, hold_bad}, 64'd0);
    chk("product", {product_hi, product_lo}, {ehi, elo});
    chk("done_cycle_flags", {61'd0, stall, busy, alu_sel}, 64'd0);
    last_hi = ehi;
    last_lo = elo;
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int dcount;
    vecs[0] = '{32'd3,          32'd5,          32'd0,          32'd15};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001};
    vecs[2] = '{32'h12345678,   32'd0,          32'd0,          32'd0};
    vecs[3] = '{32'h00010000,   32'h00010000,   32'd1,          32'd0};
    vecs[4] = '{32'hDEADBEEF,   32'd2,          32'd1,          32'hBD5B7DDE};
    vecs[5] = '{32'h80000000,   32'h80000000,   32'h40000000,   32'd0};
    vecs[6] = '{32'd0,          32'hFFFFFFFF,   32'd0,          32'd0};
    vecs[7] = '{32'd65535,      32'd65537,      32'd0,          32'hFFFFFFFF};

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    last_hi = '0; last_lo = '0;
    tick(); tick();
    chk("reset_flags", {60'd0, busy, stall, alu_sel, done}, 64'd0);
    chk("reset_product", {product_hi, product_lo}, 64'd0);
    chk("reset_alu_idle", {29'd0, alu_op, alu_a}, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) do_mult(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0);

    // start re-pulsed in RUN cycle 10 must be dropped
    do_mult(32'd9, 32'd11, 32'd0, 32'd99, 10);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      tick();
    end
    chk("ignored_start_no_done", 64'(dcount), 64'd0);
    chk("ignored_start_idle", {63'd0, busy}, 64'd0);

    // Abort with reset in RUN cycle 15
    op_a = 32'd123; op_b = 32'd456; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("pre_abort_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_flags", {60'd0, busy, stall, alu_sel, done}, 64'd0);
    chk("abort_product", {product_hi, product_lo}, 64'd0);
    last_hi = '0; last_lo = '0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      tick();
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    do_mult(32'd6, 32'd7, 32'd0, 32'd42, 0);

    // Back-to-back: second start in the IDLE cycle right after DONE
    do_mult(32'd2, 32'd3, 32'd0, 32'd6, 0);
    do_mult(32'd4, 32'd5, 32'd0, 32'd20, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
Multi-cycle controller that performs a 32x32 unsigned multiply (MULTU) using the shared EX-stage ALU for shift-add iterations.
- While active it owns the ALU through alu_sel and stalls the pipeline.
- The 64-bit product is delivered as hi/lo registers.
- It sits beside the EX stage. The EX operand/opcode muxes select between the pipeline and this block.

Parameters:
WIDTH, 32, operand width; must match ALU width
CNT_W, 6, iteration counter width, at least clog2(WIDTH)+1

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request from ID/EX to multiply op_a*op_b
op_a  in  WIDTH  multiplicand, sampled on accepted start
op_b  in  WIDTH  multiplier, sampled on accepted start
alu_result  in  WIDTH  result from the shared ALU, combinational from alu_a/alu_b/alu_op
alu_sel  out  1  1 = sequencer drives ALU inputs; EX mux select
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_op  out  3  ALU opcode
busy  out  1  multiply in progress
stall  out  1  freeze IF/ID/EX pipeline registers
done  out  1  one-cycle pulse; product valid
product_hi  out  WIDTH  upper half of product (HI)
product_lo  out  WIDTH  lower half of product (LO)

Behaviour:
- States: IDLE, RUN, DONE. Encoding is in the package.
- Reset values (rst high at a clock edge, any state):
  - state=IDLE, counter=0, internal acc/mq/mcand=0.
  - product_hi=product_lo=0, done=0.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- IDLE:
  - start=1 latches mcand=op_a, mq=op_b, acc=0, cnt=0, then goes to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle:
  - alu_a=acc, alu_b = mq[0] ? mcand : 0, alu_op=ALU_ADD (3'b010).
  - carry = (alu_result < acc), unsigned compare.
  - {acc, mq} <= {carry, alu_result, mq} >> 1, i.e. acc <= {carry, alu_result[WIDTH-1:1]} and mq <= {alu_result[0], mq[WIDTH-1:1]}.
  - cnt increments. When cnt==WIDTH-1 the final update is taken and the state goes to DONE.
- DONE, one cycle:
  - product_hi=acc, product_lo=mq, registered on entry to DONE.
  - done=1 for exactly this cycle; next state is IDLE.
- Product registers hold their value until the next completed multiply.
- Latency: start accepted at edge N, RUN occupies WIDTH cycles, done=1 in the cycle after edge N+WIDTH. This is fixed latency with no zero-operand early exit.
- busy = (state==RUN). alu_sel = (state==RUN).
- stall = (state==IDLE && start) || state==RUN. The pipeline is frozen from the request cycle until done, and released in the DONE cycle.
- Outside RUN: alu_a=0, alu_b=0, alu_op=ALU_AND (3'b000). Outputs are don't-care to the ALU because alu_sel=0.
- start while in RUN or DONE is ignored and not queued. The requester must re-issue it in IDLE.
- Back-to-back operation: start in the IDLE cycle right after DONE is accepted normally.
- Width rule: all arithmetic is unsigned WIDTH-bit through the ALU. Carry out is recovered by the compare above, so the ALU needs no carry port.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - Sequencer state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The existing ALU and the EX mux also reference these constants.
- No sub-module. FSM plus the shift register pair lives in one module, roughly 150 lines.
- The bench instantiates the team's ALU on alu_a/alu_b/alu_op -> alu_result.

Test Plan:
- op_a=3, op_b=5, start 1 cycle -> done exactly WIDTH+1 cycles after start; product_hi=0, product_lo=15; stall high from the start cycle through the last RUN cycle.
- op_a=32'hFFFFFFFF, op_b=32'hFFFFFFFF -> product_hi=32'hFFFFFFFE, product_lo=32'h00000001. Exercises the carry path every cycle.
- op_a=32'h12345678, op_b=0 -> product 0 after full 32-cycle latency. Then op_a=0x10000, op_b=0x10000 -> hi=1, lo=0.
- start re-pulsed with op_a=7, op_b=7 at RUN cycle 10 -> ignored; result is the first operands' product; only one done pulse.
- rst asserted at RUN cycle 15 -> next cycle busy=0, stall=0, alu_sel=0, product_hi/lo=0, no done. A following start with 6*7 -> lo=42.
- Two multiplies back-to-back, 2*3 then start in the cycle after done with 4*5 -> lo=6, then lo=20. product registers hold 6 until the second done.
